// File: rtl/prvp_spi_master_tx.sv
// SPI master transmit engine: pops words from a valid/ready FIFO and shifts them MSB-first, mode 0.
// Optional quad (4 bits per SCLK) datapath is built only when PRVP_SPI_TX_QUAD_EN is defined.
module prvp_spi_master_tx #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned LEN_WIDTH  = 16,
  parameter int unsigned DIV_WIDTH  = 8
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  clr_i,
  input  logic                  en_i,
  input  logic [LEN_WIDTH-1:0]  len_i,
  input  logic [DIV_WIDTH-1:0]  clk_div_i,
  input  logic                  qpi_i,
  input  logic [DATA_WIDTH-1:0] data_i,
  input  logic                  valid_i,
  output logic                  ready_o,
  output logic                  sclk_o,
  output logic [3:0]            sdo_o,
  output logic                  busy_o,
  output logic                  done_o
);

  localparam int unsigned WCW = $clog2(DATA_WIDTH + 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT_DATA,
    ST_SHIFT,
    ST_DONE
  } state_e;

  state_e                state_q, state_d;
  logic [DATA_WIDTH-1:0] shreg_q, shreg_d;
  logic [LEN_WIDTH-1:0]  rem_q, rem_d;
  logic [WCW-1:0]        wcnt_q, wcnt_d;
  logic [DIV_WIDTH-1:0]  div_cnt_q, div_cnt_d;
  logic [DIV_WIDTH-1:0]  div_q, div_d;
  logic                  sclk_q, sclk_d;

  logic                  quad_act;
  logic [3:0]            lanes;
  logic [LEN_WIDTH-1:0]  step_rem;
  logic [WCW-1:0]        step_w;
  logic [LEN_WIDTH-1:0]  rem_nxt;
  logic [WCW-1:0]        wcnt_nxt;
  logic [DATA_WIDTH-1:0] shreg_sh;

`ifdef PRVP_SPI_TX_QUAD_EN
  logic qpi_q, qpi_d;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) qpi_q <= 1'b0;
    else       qpi_q <= qpi_d;
  end

  assign quad_act = qpi_q;
  assign lanes    = qpi_q ? shreg_q[DATA_WIDTH-1 -: 4] : {3'b000, shreg_q[DATA_WIDTH-1]};
  assign shreg_sh = qpi_q ? {shreg_q[DATA_WIDTH-5:0], 4'b0000} : {shreg_q[DATA_WIDTH-2:0], 1'b0};
`else
  logic unused_qpi;
  assign unused_qpi = qpi_i;
  assign quad_act   = 1'b0;
  assign lanes      = {3'b000, shreg_q[DATA_WIDTH-1]};
  assign shreg_sh   = {shreg_q[DATA_WIDTH-2:0], 1'b0};
`endif

  assign step_rem = quad_act ? LEN_WIDTH'(4) : LEN_WIDTH'(1);
  assign step_w   = quad_act ? WCW'(4) : WCW'(1);
  // Saturating decrement lets a quad transfer round a short tail up to a full nibble.
  assign rem_nxt  = (rem_q > step_rem) ? rem_q - step_rem : '0;
  assign wcnt_nxt = (wcnt_q > step_w) ? wcnt_q - step_w : '0;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= ST_IDLE;
      shreg_q   <= '0;
      rem_q     <= '0;
      wcnt_q    <= '0;
      div_cnt_q <= '0;
      div_q     <= '0;
      sclk_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      shreg_q   <= shreg_d;
      rem_q     <= rem_d;
      wcnt_q    <= wcnt_d;
      div_cnt_q <= div_cnt_d;
      div_q     <= div_d;
      sclk_q    <= sclk_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    shreg_d   = shreg_q;
    rem_d     = rem_q;
    wcnt_d    = wcnt_q;
    div_cnt_d = div_cnt_q;
    div_d     = div_q;
    sclk_d    = sclk_q;
`ifdef PRVP_SPI_TX_QUAD_EN
    qpi_d     = qpi_q;
`endif

    case (state_q)
      ST_IDLE: begin
        sclk_d    = 1'b0;
        div_cnt_d = '0;
        if (en_i) begin
          rem_d = len_i;
          div_d = clk_div_i;
`ifdef PRVP_SPI_TX_QUAD_EN
          qpi_d = qpi_i;
`endif
          state_d = (len_i == '0) ? ST_DONE : ST_WAIT_DATA;
        end
      end
      ST_WAIT_DATA: begin
        sclk_d    = 1'b0;
        div_cnt_d = '0;
        if (valid_i) begin
          shreg_d = data_i;
          wcnt_d  = WCW'(DATA_WIDTH);
          state_d = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        if (div_cnt_q == div_q) begin
          div_cnt_d = '0;
          if (!sclk_q) begin
            sclk_d = 1'b1;
          end else begin
            sclk_d  = 1'b0;
            shreg_d = shreg_sh;
            rem_d   = rem_nxt;
            wcnt_d  = wcnt_nxt;
            if (rem_nxt == '0)       state_d = ST_DONE;
            else if (wcnt_nxt == '0) state_d = ST_WAIT_DATA;
          end
        end else begin
          div_cnt_d = div_cnt_q + 1'b1;
        end
      end
      ST_DONE: begin
        sclk_d  = 1'b0;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    // Abort wins over every transition, including a pop in the same cycle.
    if (clr_i) begin
      state_d   = ST_IDLE;
      sclk_d    = 1'b0;
      div_cnt_d = '0;
    end
  end

  assign ready_o = (state_q == ST_WAIT_DATA);
  assign busy_o  = (state_q != ST_IDLE);
  assign done_o  = (state_q == ST_DONE);
  assign sclk_o  = sclk_q;
  assign sdo_o   = (state_q == ST_SHIFT) ? lanes : 4'b0000;

endmodule

// File: tb/tb_prvp_spi_master_tx.sv
// Directed bench for prvp_spi_master_tx: FIFO model, SCLK-rise data capture, scored checks.
module tb_prvp_spi_master_tx;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        clr_i = 1'b0;
  logic        en_i = 1'b0;
  logic [15:0] len_i = '0;
  logic [7:0]  clk_div_i = '0;
  logic        qpi_i = 1'b0;
  logic [31:0] data_i = '0;
  logic        valid_i = 1'b0;
  logic        ready_o, sclk_o, busy_o, done_o;
  logic [3:0]  sdo_o;

  prvp_spi_master_tx #(.DATA_WIDTH(32), .LEN_WIDTH(16), .DIV_WIDTH(8)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .clr_i(clr_i), .en_i(en_i), .len_i(len_i),
    .clk_div_i(clk_div_i), .qpi_i(qpi_i), .data_i(data_i), .valid_i(valid_i),
    .ready_o(ready_o), .sclk_o(sclk_o), .sdo_o(sdo_o), .busy_o(busy_o), .done_o(done_o)
  );

  always #5 clk_i = ~clk_i;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // FIFO model: words pushed by the stimulus, popped on valid&ready, optional gap after each pop.
  logic [31:0] fifo_mem [8];
  int wr_ptr = 0;
  int rd_ptr = 0;
  int gap_cfg = 0;
  int gap_cnt = 0;
  int pops = 0;
  logic pop_pend = 1'b0;

  always @(posedge clk_i) begin
    #1;
    if (pop_pend) begin
      rd_ptr++;
      pops++;
      gap_cnt = gap_cfg;
    end else if (gap_cnt > 0) begin
      gap_cnt--;
    end
    valid_i = (rd_ptr != wr_ptr) && (gap_cnt == 0);
    data_i  = fifo_mem[rd_ptr % 8];
  end

  // Monitor sampled on the falling clk_i edge.
  int cyc = 0, rises = 0, dones = 0, done_cyc = 0;
  int rise_prev = 0, rise_last = 0;
  int lane_bad = 0, wait_sclk_bad = 0, wait_cyc = 0;
  logic single_tb = 1'b1;
  logic sclk_prev = 1'b0;
  logic [63:0] acc1 = '0;
  logic [63:0] acc4 = '0;

  always @(negedge clk_i) begin
    cyc++;
    pop_pend = ready_o && valid_i;
    if (sclk_o && !sclk_prev) begin
      rises++;
      rise_prev = rise_last;
      rise_last = cyc;
      acc1 = {acc1[62:0], sdo_o[0]};
      acc4 = {acc4[59:0], sdo_o};
      if (single_tb && (sdo_o[3:1] != 3'b000)) lane_bad++;
    end
    if (ready_o && sclk_o) wait_sclk_bad++;
    if (ready_o) wait_cyc++;
    if (done_o) begin
      dones++;
      done_cyc = cyc;
    end
    sclk_prev = sclk_o;
  end

  int b_rises, b_pops, b_dones, b_lane, b_wsb, b_wait, en_cyc;

  task automatic push(input logic [31:0] w);
    fifo_mem[wr_ptr % 8] = w;
    wr_ptr++;
  endtask

  task automatic start(input int len, input int div, input logic qpi);
    b_rises = rises; b_pops = pops; b_dones = dones;
    b_lane = lane_bad; b_wsb = wait_sclk_bad; b_wait = wait_cyc;
    @(posedge clk_i); #1;
    en_i = 1'b1; len_i = 16'(len); clk_div_i = 8'(div); qpi_i = qpi;
    en_cyc = cyc;
    @(posedge clk_i); #1;
    en_i = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int n = 0;
    while ((dones == b_dones) && (n < budget)) begin
      @(negedge clk_i); #1;
      n++;
    end
    if (dones == b_dones) check("timeout_done", 64'd0, 64'd1);
    repeat (4) @(negedge clk_i);
    #1;
  endtask

  task automatic wait_rises(input int k, input int budget);
    int n = 0;
    while (((rises - b_rises) < k) && (n < budget)) begin
      @(negedge clk_i); #1;
      n++;
    end
    if ((rises - b_rises) < k) check("timeout_rise", 64'd0, 64'd1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    // Reset state
    #22 rst_i = 1'b0;
    @(negedge clk_i); #1;
    check("rst_sclk",  64'(sclk_o),  64'd0);
    check("rst_sdo",   64'(sdo_o),   64'd0);
    check("rst_ready", 64'(ready_o), 64'd0);
    check("rst_busy",  64'(busy_o),  64'd0);
    check("rst_done",  64'(done_o),  64'd0);

    // 1: single word, 8 bits, div=1
    push(32'hA500_0000);
    start(8, 1, 1'b0);
    wait_done(400);
    check("t1_rises", 64'(rises - b_rises), 64'd8);
    check("t1_bits",  64'(acc1[7:0]), 64'hA5);
    check("t1_pops",  64'(pops - b_pops), 64'd1);
    check("t1_done",  64'(dones - b_dones), 64'd1);
    check("t1_period", 64'(rise_last - rise_prev), 64'd4);
    check("t1_lanes", 64'(lane_bad - b_lane), 64'd0);
    check("t1_idle",  64'(busy_o), 64'd0);

    // 2: two words, div=0, second word late so the engine stalls in WAIT_DATA
    gap_cfg = 75;
    push(32'hDEAD_BEEF);
    push(32'h1234_5678);
    start(64, 0, 1'b0);
    wait_done(2000);
    gap_cfg = 0;
    check("t2_rises", 64'(rises - b_rises), 64'd64);
    check("t2_bits",  acc1, 64'hDEAD_BEEF_1234_5678);
    check("t2_pops",  64'(pops - b_pops), 64'd2);
    check("t2_done",  64'(dones - b_dones), 64'd1);
    check("t2_stalled", 64'((wait_cyc - b_wait) > 3), 64'd1);
    check("t2_sclk_low_wait", 64'(wait_sclk_bad - b_wsb), 64'd0);
    check("t2_period", 64'(rise_last - rise_prev), 64'd2);

    // 3: zero length
    start(0, 1, 1'b0);
    wait_done(50);
    check("t3_done",    64'(dones - b_dones), 64'd1);
    check("t3_latency", 64'(done_cyc - en_cyc), 64'd2);
    check("t3_rises",   64'(rises - b_rises), 64'd0);
    check("t3_pops",    64'(pops - b_pops), 64'd0);

    // 4: quad request, len=12 (single-mode fallback when quad is not built)
    push(32'h3C5F_FFFF);
`ifdef PRVP_SPI_TX_QUAD_EN
    single_tb = 1'b0;
    start(12, 1, 1'b1);
    wait_done(400);
    check("t4_rises", 64'(rises - b_rises), 64'd3);
    check("t4_nibbles", 64'(acc4[11:0]), 64'h3C5);
    single_tb = 1'b1;
`else
    start(12, 1, 1'b1);
    wait_done(400);
    check("t4_rises", 64'(rises - b_rises), 64'd12);
    check("t4_bits",  64'(acc1[11:0]), 64'h3C5);
    check("t4_lanes", 64'(lane_bad - b_lane), 64'd0);
`endif
    check("t4_pops", 64'(pops - b_pops), 64'd1);
    check("t4_done", 64'(dones - b_dones), 64'd1);

    // 5a: synchronous abort after 5 of 16 bits
    push(32'hF0F0_0000);
    start(16, 1, 1'b0);
    wait_rises(5, 200);
    @(posedge clk_i); #1;
    clr_i = 1'b1;
    @(posedge clk_i); #1;
    clr_i = 1'b0;
    @(negedge clk_i); #1;
    check("t5_clr_sclk", 64'(sclk_o), 64'd0);
    check("t5_clr_busy", 64'(busy_o), 64'd0);
    repeat (5) @(negedge clk_i);
    #1;
    check("t5_clr_rises", 64'(rises - b_rises), 64'd5);
    check("t5_clr_nodone", 64'(dones - b_dones), 64'd0);

    push(32'hA500_0000);
    start(8, 1, 1'b0);
    wait_done(400);
    check("t5_after_clr_bits", 64'(acc1[7:0]), 64'hA5);
    check("t5_after_clr_rises", 64'(rises - b_rises), 64'd8);

    // 5b: asynchronous reset while SCLK is high
    push(32'hFFFF_0000);
    start(16, 1, 1'b0);
    wait_rises(3, 200);
    #2 rst_i = 1'b1;
    #1;
    check("t5_rst_sclk",  64'(sclk_o),  64'd0);
    check("t5_rst_busy",  64'(busy_o),  64'd0);
    check("t5_rst_sdo",   64'(sdo_o),   64'd0);
    @(negedge clk_i); #2;
    rst_i = 1'b0;
    repeat (3) @(negedge clk_i);
    #1;
    check("t5_rst_nodone", 64'(dones - b_dones), 64'd0);

    push(32'h5A00_0000);
    start(8, 1, 1'b0);
    wait_done(400);
    check("t5_after_rst_bits", 64'(acc1[7:0]), 64'h5A);
    check("t5_after_rst_pops", 64'(pops - b_pops), 64'd1);

    // 6: en_i with new settings while busy is ignored
    push(32'hC3A5_0000);
    start(16, 1, 1'b0);
    repeat (6) @(posedge clk_i);
    #1;
    en_i = 1'b1; len_i = 16'd4; clk_div_i = 8'd0;
    @(posedge clk_i); #1;
    en_i = 1'b0;
    wait_done(400);
    check("t6_rises",  64'(rises - b_rises), 64'd16);
    check("t6_bits",   64'(acc1[15:0]), 64'hC3A5);
    check("t6_pops",   64'(pops - b_pops), 64'd1);
    check("t6_done",   64'(dones - b_dones), 64'd1);
    check("t6_period", 64'(rise_last - rise_prev), 64'd4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
